// File: rtl/sqrt16_seq_if.sv
// Request/result bundle for the sequential 16-bit square-root unit.
// The requester drives start_i/radicand_i; the unit returns status and result.
interface sqrt16_seq_if;
  logic        start_i;
  logic [15:0] radicand_i;
  logic        busy_o;
  logic        done_o;
  logic [7:0]  root_o;
  logic [8:0]  rem_o;

  modport master (
    output start_i, radicand_i,
    input  busy_o, done_o, root_o, rem_o
  );

  modport slave (
    input  start_i, radicand_i,
    output busy_o, done_o, root_o, rem_o
  );
endinterface

// File: rtl/sqrt16_seq.sv
// Restoring digit-by-digit square root, one root bit per clock, using a
// 16-bit 4x4 carry-lookahead adder for the trial subtraction.
module sqrt16_seq (
  input logic         clk_i,
  input logic         rst_i,
  sqrt16_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state_q, state_d;
  logic [15:0] x_q, x_d;
  logic [9:0]  r_q, r_d;
  logic [7:0]  q_q, q_d;
  logic [2:0]  it_q, it_d;
  logic [7:0]  root_q, root_d;
  logic [8:0]  rem_q, rem_d;

  logic [11:0] r_sh;
  logic [9:0]  trial;
  logic [15:0] a_in, b_in;
  logic [15:0] g, p, c;
  logic [3:0]  gg, gp;
  logic [4:0]  cg;
  logic [9:0]  sum;
  logic        ge;

  // Trial subtraction r_sh - trial as r_sh + ~trial + 1; carry out means r_sh >= trial.
  always_comb begin
    r_sh  = {r_q, x_q[15:14]};
    trial = {q_q, 2'b01};
    a_in  = {4'b0000, r_sh};
    b_in  = ~{6'b000000, trial};
    g     = a_in & b_in;
    p     = a_in ^ b_in;
    for (int k = 0; k < 4; k++) begin
      gg[k] = g[4*k+3]
            | (p[4*k+3] & g[4*k+2])
            | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
      gp[k] = &p[4*k +: 4];
    end
    cg[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cg[k+1] = gg[k] | (gp[k] & cg[k]);
    end
    c[0] = cg[0];
    for (int i = 0; i < 15; i++) begin
      if ((i % 4) == 3) c[i+1] = cg[(i/4)+1];
      else              c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum = p[9:0] ^ c[9:0];
    ge  = cg[4];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      r_q     <= '0;
      q_q     <= '0;
      it_q    <= '0;
      root_q  <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      r_q     <= r_d;
      q_q     <= q_d;
      it_q    <= it_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    r_d     = r_q;
    q_d     = q_q;
    it_d    = it_q;
    root_d  = root_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE, DONE: begin
        if (bus.start_i) begin
          state_d = CALC;
          x_d     = bus.radicand_i;
          r_d     = '0;
          q_d     = '0;
          it_d    = 3'd7;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        x_d  = {x_q[13:0], 2'b00};
        it_d = it_q - 3'd1;
        r_d  = ge ? sum : r_sh[9:0];
        q_d  = {q_q[6:0], ge};
        // Results are published only on the completing edge so they stay stable meanwhile.
        if (it_q == 3'd0) begin
          state_d = DONE;
          root_d  = q_d;
          rem_d   = r_d[8:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy_o = (state_q == CALC);
    bus.done_o = (state_q == DONE);
    bus.root_o = root_q;
    bus.rem_o  = rem_q;
  end

endmodule

// File: doc/sqrt16_seq.md
# sqrt16_seq

Sequential integer square-root unit for 16-bit unsigned radicands, producing an 8-bit root and a 9-bit remainder. It sits directly upstream of the 16-bit 4x4 carry-lookahead adder (CLA4x4) and drives it every iteration. The adder's A_i, B_i and Ci_i inputs are fed with a two's-complement trial subtraction, and its S_o/Co_o results are consumed to decide each root bit. One root bit is resolved per clock using the restoring digit-by-digit algorithm, so a full result takes 8 iteration cycles.

## Interface
- Parameters: none. Widths are fixed by the 16-bit adder datapath.
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset. **Synchronous, active-high.**
- start_i  input  1  request. Sampled only when not busy.
- radicand_i  input  16  unsigned operand. Captured on the accepting edge.
- busy_o  output  1  high while iterating (state CALC).
- done_o  output  1  one-cycle pulse; root_o/rem_o valid and newly updated.
- root_o  output  8  floor(sqrt(radicand)). Held until the next completion.
- rem_o  output  9  radicand − root². Held until the next completion.

## Operation
- States:
  - IDLE: waiting for a request.
  - CALC: iterating, tracked by a 3-bit counter it = 7..0.
  - DONE: one cycle, done_o = 1.
- IDLE/DONE → CALC on start_i = 1. On that edge:
  - load x ← radicand_i, r ← 0, q ← 0, it ← 7;
  - busy_o rises.
- Without start_i: DONE → IDLE, IDLE → IDLE.
- CALC iteration, per edge:
  - r_sh = {r, x[15:14]}, 11 bits;
  - trial = {q, 2'b01}, 10 bits;
  - adder A_i = zero-extend(r_sh); B_i = ~zero-extend(trial); Ci_i = 1;
  - ge = Co_o, meaning r_sh ≥ trial.
- Updates each iteration:
  - if ge: r ← S_o[9:0], q ← {q[6:0], 1};
  - else: r ← r_sh[9:0], q ← {q[6:0], 0};
  - x ← x << 2; it ← it − 1.
- Width guarantees:
  - r never exceeds 2q, so at most 510, and fits 9 bits at completion;
  - r_sh fits 11 bits;
  - the upper 5 bits of S_o are 0 whenever ge = 1;
  - no overflow is possible for any 16-bit input.
- CALC with it = 0: perform the final iteration, then:
  - state → DONE;
  - root_o ← final q; rem_o ← final r[8:0];
  - busy_o falls; done_o rises.
- start_i while in CALC is ignored. The request is not queued, and the operation in progress is unaffected.
- Outputs root_o/rem_o change only on a completing edge. They are never disturbed by a new start before that start's own completion.
- Reset, including mid-CALC, on the rst_i edge:
  - state → IDLE; busy_o = 0, done_o = 0, root_o = 0, rem_o = 0;
  - internal x, r, q, it are cleared;
  - the in-flight operation is discarded, with no done pulse.
  - rst_i has priority over start_i.

## Timing
- Accept edge E0 → iteration edges E1..E8 → done_o high for exactly the cycle after E8.
- Latency is 8 cycles from the accept edge to done.
- busy_o is high from after E0 through the cycle before E8 completes, and low after E8.
- Back-to-back: start_i high during the DONE cycle is accepted.
  - This gives one result every 9 cycles.
  - done_o and busy_o never assert together.
- The adder is used combinationally within each CALC cycle. The single-cycle path is r/q register → adder → r/q register.
- The adder inputs are don't-care outside CALC. They are driven from the current registers, so there is no gating requirement.

## Test plan
- Reset, then radicand 0 → done_o after 8 iteration cycles with root 0, rem 0; busy_o high for exactly 8 cycles.
- Radicand 65535 → root 255, rem 510. Radicand 144 → root 12, rem 0. Radicand 143 → root 11, rem 22.
- Back-to-back: start 100 at E0 and start 99 in its DONE cycle → root 10/rem 0 one cycle after E8, then root 9/rem 18 exactly 9 cycles later. root_o holds 10 between the two results.
- Start 400, then pulse start_i with 1 at E3 → that second start is ignored; root 20, rem 0; no second done_o.
- rst_i asserted at E5 of an operation on 50000 → all outputs 0 next cycle, no done_o. A following start of 50000 → root 223, rem 271.
- Exhaustive sweep 0..65535 against a reference model: root² + rem = radicand and rem ≤ 2·root for every value.
